// File: rtl/rv32i_multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> class-specific EXE/MEM/WB.
// Optional `BUS_WAIT_EN adds busReady back-pressure on the S_MEM/L_MEM bus states.
module rv32i_multicycle_ctrl #(
  parameter bit RESET_STATE_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef BUS_WAIT_EN
  input  logic        busReady,
`endif
  input  logic [31:0] instrCode,
  output logic        pcEn,
  output logic        irEn,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic [3:0]  aluControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busWe,
  output logic [2:0]  strb,
  output logic        illegalInstr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, L_EXE, S_EXE, B_EXE, LU_EXE,
    AU_EXE, J_EXE, JL_EXE, S_MEM, L_MEM, L_WB, TRAP
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam state_e RESET_STATE = RESET_STATE_FETCH ? FETCH : DECODE;

  state_e      state_q, state_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        bit30;
  logic        bus_ready;
  logic        unused_instr_bits;

  assign opcode = instrCode[6:0];
  assign funct3 = instrCode[14:12];
  assign bit30  = instrCode[30];
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

`ifdef BUS_WAIT_EN
  assign bus_ready = busReady;
`else
  assign bus_ready = 1'b1;
`endif

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    pcEn          = 1'b0;
    irEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = 4'b0000;
    RFWDSrcMuxSel = 3'd0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    busWe         = 1'b0;
    strb          = 3'b000;
    illegalInstr  = 1'b0;

    unique case (state_q)
      FETCH: begin
        irEn    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        unique case (opcode)
          OP_R:    state_d = R_EXE;
          OP_I:    state_d = I_EXE;
          OP_L:    state_d = L_EXE;
          OP_S:    state_d = S_EXE;
          OP_B:    state_d = B_EXE;
          OP_LU:   state_d = LU_EXE;
          OP_AU:   state_d = AU_EXE;
          OP_J:    state_d = J_EXE;
          OP_JL:   state_d = JL_EXE;
          default: state_d = TRAP;
        endcase
      end
      R_EXE: begin
        aluControl = {bit30, funct3};
        regFileWe  = 1'b1;
        pcEn       = 1'b1;
        state_d    = FETCH;
      end
      I_EXE: begin
        // bit30 only matters for shifts-right; ADDI with bit30 set must stay an add.
        aluSrcMuxSel = 1'b1;
        aluControl   = {bit30 & (funct3 == 3'b101), funct3};
        regFileWe    = 1'b1;
        pcEn         = 1'b1;
        state_d      = FETCH;
      end
      B_EXE: begin
        aluControl = {1'b0, funct3};
        branch     = 1'b1;
        pcEn       = 1'b1;
        state_d    = FETCH;
      end
      LU_EXE: begin
        RFWDSrcMuxSel = 3'd2;
        regFileWe     = 1'b1;
        pcEn          = 1'b1;
        state_d       = FETCH;
      end
      AU_EXE: begin
        RFWDSrcMuxSel = 3'd3;
        regFileWe     = 1'b1;
        pcEn          = 1'b1;
        state_d       = FETCH;
      end
      J_EXE: begin
        jal           = 1'b1;
        RFWDSrcMuxSel = 3'd4;
        regFileWe     = 1'b1;
        pcEn          = 1'b1;
        state_d       = FETCH;
      end
      JL_EXE: begin
        jalr          = 1'b1;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = 3'd4;
        regFileWe     = 1'b1;
        pcEn          = 1'b1;
        state_d       = FETCH;
      end
      S_EXE: begin
        aluSrcMuxSel = 1'b1;
        state_d      = S_MEM;
      end
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        strb         = funct3;
        busWe        = 1'b1;
        if (bus_ready) begin
          pcEn    = 1'b1;
          state_d = FETCH;
        end
      end
      L_EXE: begin
        aluSrcMuxSel = 1'b1;
        state_d      = L_MEM;
      end
      L_MEM: begin
        aluSrcMuxSel = 1'b1;
        strb         = funct3;
        if (bus_ready) state_d = L_WB;
      end
      L_WB: begin
        aluSrcMuxSel  = 1'b1;
        strb          = funct3;
        RFWDSrcMuxSel = 3'd1;
        regFileWe     = 1'b1;
        pcEn          = 1'b1;
        state_d       = FETCH;
      end
      TRAP: begin
        illegalInstr = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    // Reset silences the datapath immediately, before the async state flop is even seen.
    if (reset) begin
      pcEn          = 1'b0;
      irEn          = 1'b0;
      regFileWe     = 1'b0;
      aluSrcMuxSel  = 1'b0;
      aluControl    = 4'b0000;
      RFWDSrcMuxSel = 3'd0;
      branch        = 1'b0;
      jal           = 1'b0;
      jalr          = 1'b0;
      busWe         = 1'b0;
      strb          = 3'b000;
      illegalInstr  = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed bench for rv32i_multicycle_ctrl: per-cycle output vectors for each
// instruction class, trap, async reset, and bus wait when BUS_WAIT_EN is defined.
module tb_rv32i_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_code = '0;
`ifdef BUS_WAIT_EN
  logic        bus_ready = 1'b1;
`endif
  logic        pc_en, ir_en, rf_we, alu_src, br, jal_o, jalr_o, bus_we, illegal;
  logic [3:0]  alu_ctl;
  logic [2:0]  rfwd_sel, strb;

  int checks = 0;
  int errors = 0;

  logic [18:0] outs;
  logic [18:0] f_v, z_v;
  logic [18:0] ev [5];

  rv32i_multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
`ifdef BUS_WAIT_EN
    .busReady     (bus_ready),
`endif
    .instrCode    (instr_code),
    .pcEn         (pc_en),
    .irEn         (ir_en),
    .regFileWe    (rf_we),
    .aluSrcMuxSel (alu_src),
    .aluControl   (alu_ctl),
    .RFWDSrcMuxSel(rfwd_sel),
    .branch       (br),
    .jal          (jal_o),
    .jalr         (jalr_o),
    .busWe        (bus_we),
    .strb         (strb),
    .illegalInstr (illegal)
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, ir_en, rf_we, alu_src, alu_ctl, rfwd_sel, br, jal_o, jalr_o,
                 bus_we, strb, illegal};

  function automatic logic [18:0] ov(input logic pc, ir, we, src, input logic [3:0] alu,
                                     input logic [2:0] rf, input logic b, j, jr, bwe,
                                     input logic [2:0] sb, input logic ill);
    return {pc, ir, we, src, alu, rf, b, j, jr, bwe, sb, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h", tag, act, exp);
    end
  endtask

  // Starts on a FETCH cycle; checks n cycles against ev[] then the following FETCH.
  task automatic run(input string tag, input logic [31:0] instr, input int n);
    instr_code = instr;
    #1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d", tag, i + 1), {13'b0, outs}, {13'b0, ev[i]});
      @(negedge clk);
    end
    check({tag, "_next_fetch"}, {13'b0, outs}, {13'b0, f_v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    f_v = ov(0,1,0,0,4'b0000,3'd0,0,0,0,0,3'b000,0);
    z_v = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_zero", {13'b0, outs}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    ev = '{f_v, z_v, ov(1,0,1,0,4'b0000,3'd0,0,0,0,0,3'b000,0), z_v, z_v};
    run("add", 32'h002081B3, 3);
    ev = '{f_v, z_v, ov(1,0,1,0,4'b1000,3'd0,0,0,0,0,3'b000,0), z_v, z_v};
    run("sub", 32'h40000033, 3);
    ev = '{f_v, z_v, ov(1,0,1,1,4'b1101,3'd0,0,0,0,0,3'b000,0), z_v, z_v};
    run("srai", 32'h4020D193, 3);
    ev = '{f_v, z_v, ov(1,0,1,1,4'b0000,3'd0,0,0,0,0,3'b000,0), z_v, z_v};
    run("addi_b30", 32'h40008193, 3);
    ev = '{f_v, z_v, ov(1,0,0,0,4'b0001,3'd0,1,0,0,0,3'b000,0), z_v, z_v};
    run("bne_b30", 32'h40209463, 3);
    ev = '{f_v, z_v, ov(1,0,1,0,4'b0000,3'd2,0,0,0,0,3'b000,0), z_v, z_v};
    run("lui", 32'h123450B7, 3);
    ev = '{f_v, z_v, ov(1,0,1,0,4'b0000,3'd3,0,0,0,0,3'b000,0), z_v, z_v};
    run("auipc", 32'h00000097, 3);
    ev = '{f_v, z_v, ov(1,0,1,0,4'b0000,3'd4,0,1,0,0,3'b000,0), z_v, z_v};
    run("jal", 32'h0000006F, 3);
    ev = '{f_v, z_v, ov(1,0,1,1,4'b0000,3'd4,0,0,1,0,3'b000,0), z_v, z_v};
    run("jalr", 32'h00008067, 3);
    ev = '{f_v, z_v, ov(0,0,0,1,4'b0000,3'd0,0,0,0,0,3'b000,0),
           ov(1,0,0,1,4'b0000,3'd0,0,0,0,1,3'b010,0), z_v};
    run("sw", 32'h0020A223, 4);
    ev = '{f_v, z_v, ov(0,0,0,1,4'b0000,3'd0,0,0,0,0,3'b000,0),
           ov(0,0,0,1,4'b0000,3'd0,0,0,0,0,3'b100,0),
           ov(1,0,1,1,4'b0000,3'd1,0,0,0,0,3'b100,0)};
    run("lbu", 32'h0040C183, 5);

    // Abandon a load in L_MEM with an asynchronous reset.
    instr_code = 32'h0040C183;
    repeat (3) @(negedge clk);
    #1;
    check("lmem_before_rst", {13'b0, outs}, {13'b0, ev[3]});
    reset = 1'b1;
    #1;
    check("rst_in_lmem_zero", {13'b0, outs}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run("lbu_after_rst", 32'h0040C183, 5);

    // Illegal opcode: trap is sticky, PC frozen.
    instr_code = 32'hFFFFFFFF;
    #1;
    check("trap_fetch", {13'b0, outs}, {13'b0, f_v});
    @(negedge clk);
    check("trap_decode", {13'b0, outs}, {13'b0, z_v});
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("trap_hold_%0d", i), {13'b0, outs},
            {13'b0, ov(0,0,0,0,4'b0000,3'd0,0,0,0,0,3'b000,1)});
      @(negedge clk);
    end
    #2;
    reset = 1'b1;
    #1;
    check("trap_rst_illegal", {31'b0, illegal}, 32'h0);
    check("trap_rst_all_zero", {13'b0, outs}, 32'h0);

`ifdef BUS_WAIT_EN
    begin
      int we_cnt, pc_cnt;
      we_cnt = 0;
      pc_cnt = 0;
      @(negedge clk);
      reset = 1'b0;
      instr_code = 32'h0020A223;
      for (int i = 0; i < 7; i++) begin
        bus_ready = (i >= 6);
        #1;
        if (bus_we) we_cnt++;
        if (pc_en)  pc_cnt++;
        @(negedge clk);
      end
      bus_ready = 1'b1;
      #1;
      check("wait_buswe_cycles", we_cnt, 4);
      check("wait_pcen_count", pc_cnt, 1);
      check("wait_next_fetch", {13'b0, outs}, {13'b0, f_v});
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
